regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Integer register file (x0..x31) directly upstream of the rs1/rs2 operand latches; supplies the regfile-path operand data they capture for R/S/B-type instructions.
- Two registered read ports, one writeback port with write-to-read bypass.
- Per-register busy scoreboard: marks destinations of in-flight instructions and raises a stall while a source operand is still pending.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports
- NREG, 32, number of architectural registers; address width is fixed at 5 bits

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- rd_en  input  1  read request for rs1_addr/rs2_addr this cycle
- rs1_addr  input  5  source register 1 index
- rs2_addr  input  5  source register 2 index
- rs1_read_data  output  XLEN  registered rs1 operand
- rs2_read_data  output  XLEN  registered rs2 operand
- rd_valid  output  1  one-cycle pulse; read data updated this cycle
- stall  output  1  combinational; read request is blocked this cycle
- issue_valid  input  1  instruction issued with a destination register
- issue_rd  input  5  destination index of the issued instruction
- issue_err  output  1  registered one-cycle pulse; issue rejected (WAW on a busy register)
- wb_en  input  1  writeback strobe
- wb_addr  input  5  writeback destination index
- wb_data  input  XLEN  writeback value
- busy_mask  output  NREG  current scoreboard state, bit i = register i pending

Behaviour:
- Reset (rst=0, asynchronous, applies mid-operation): all registers = 0; busy_mask = 0; rs1_read_data = rs2_read_data = 0; rd_valid = 0; issue_err = 0. Any in-flight read or issue is discarded.
- x0 rules:
  - Always reads 0.
  - Writes to x0 are ignored.
  - issue_rd=0 never sets busy and never raises issue_err.
  - busy_mask[0] is always 0.
- Writeback: on a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data and busy[wb_addr] is cleared.
- Effective busy, per source s, is defined as busy[s] && !(wb_en && wb_addr==s).
- stall = rd_en && (effective busy of rs1_addr || effective busy of rs2_addr). It is combinational and does not depend on issue_valid in the same cycle.
- Read accept: when rd_en=1 and stall=0, on the next edge:
  - rsN_read_data <= wb_data if wb_en && wb_addr==rsN_addr && rsN_addr!=0 (bypass); otherwise reg[rsN_addr].
  - rd_valid <= 1.
  - Latency is 1 cycle.
- No accept (stall=1 or rd_en=0): read data holds its previous value; rd_valid <= 0.
- Issue: on an edge with issue_valid=1 and issue_rd!=0:
  - If busy[issue_rd]=0, or it is being cleared by writeback this same edge: busy[issue_rd] <= 1. Set beats clear when both target the same register.
  - If busy[issue_rd]=1 and it is not being cleared this edge: busy unchanged; issue_err <= 1 for one cycle.
- issue_err is 0 on every edge where no rejected issue occurs.
- Writeback to a register that is not busy is legal: data is written and busy stays 0.
- Reads, issue and writeback are mutually independent. All three may occur on the same edge to the same register; the rules above compose. Example: read of r sees the bypassed wb_data, and r ends the cycle busy because of the new issue.

Test Plan:
- Reset then read: release rst, rd_en=1, rs1=5, rs2=0 -> next cycle rd_valid=1, both outputs 0x0000_0000, busy_mask=0.
- Write then read with bypass: wb_en=1, wb_addr=3, wb_data=0xDEAD_BEEF, with rd_en=1, rs1=3 on the same edge -> rs1_read_data=0xDEAD_BEEF after 1 cycle. A later read of r3 also returns 0xDEAD_BEEF.
- x0 immutability: wb_addr=0, wb_data=0xFFFF_FFFF; issue_rd=0 -> read of x0 returns 0; busy_mask[0]=0; issue_err=0.
- Scoreboard stall and release:
  - Issue rd=7; next cycle rd_en=1, rs2=7 -> stall=1, rd_valid=0, outputs hold.
  - wb_en=1, wb_addr=7, wb_data=0x1234 in a later cycle -> stall drops the same cycle; rs2_read_data=0x0000_1234 next cycle; busy_mask[7]=0.
- WAW and same-cycle set/clear:
  - Issue rd=9 twice on consecutive cycles -> issue_err pulses once; busy[9] stays 1.
  - Then wb to r9 together with a new issue rd=9 on the same edge -> busy[9]=1 and issue_err=0.
- Async reset mid-operation: with busy_mask=0x0000_0480 and rd_valid=1, assert rst between clock edges -> all outputs 0 immediately; registers read 0 after release.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with two registered read ports, writeback bypass and a
// per-register busy scoreboard that stalls reads of pending operands.
module regfile_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_read_data,
  output logic [XLEN-1:0] rs2_read_data,
  output logic            rd_valid,
  output logic            stall,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_err,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy_mask
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic            rd_valid_q, rd_valid_d;
  logic            issue_err_q, issue_err_d;

  logic wb_hit;
  logic rs1_pending, rs2_pending;

  assign wb_hit = wb_en && (wb_addr != 5'd0);

  // A writeback landing this edge releases the operand in the same cycle.
  assign rs1_pending = busy_q[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
  assign rs2_pending = busy_q[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
  assign stall       = rd_en && (rs1_pending || rs2_pending);

  always_comb begin
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_valid_d = 1'b0;
    if (rd_en && !stall) begin
      rd_valid_d = 1'b1;
      rs1_d      = (wb_hit && (wb_addr == rs1_addr)) ? wb_data : regs_q[rs1_addr];
      rs2_d      = (wb_hit && (wb_addr == rs2_addr)) ? wb_data : regs_q[rs2_addr];
    end
  end

  always_comb begin
    busy_d      = busy_q;
    issue_err_d = 1'b0;
    if (wb_hit) begin
      busy_d[wb_addr] = 1'b0;
    end
    // Set is applied after clear so a same-edge issue wins.
    if (issue_valid && (issue_rd != 5'd0)) begin
      if (!busy_q[issue_rd] || (wb_hit && (wb_addr == issue_rd))) begin
        busy_d[issue_rd] = 1'b1;
      end else begin
        issue_err_d = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_valid_q  <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_valid_q  <= rd_valid_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign rs1_read_data = rs1_q;
  assign rs2_read_data = rs2_q;
  assign rd_valid      = rd_valid_q;
  assign issue_err     = issue_err_q;
  assign busy_mask     = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: reset, bypass, x0,
// scoreboard stall/release, WAW rejection and asynchronous reset.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_read_data, rs2_read_data;
  logic        rd_valid, stall;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_err;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_read_data (rs1_read_data),
    .rs2_read_data (rs2_read_data),
    .rd_valid      (rd_valid),
    .stall         (stall),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_err     (issue_err),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || busy_mask !== 32'h0 || issue_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_valid=%b busy=%h err=%b, want 0/0/0",
               rd_valid, busy_mask, issue_err);
    end
    rst = 1'b1;
    tick();
    rd_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_read_valid: got %b want 1", rd_valid);
    end
    n_checks++;
    if (rs1_read_data !== 32'h0 || rs2_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_data: rs1=%h rs2=%h want 0/0", rs1_read_data, rs2_read_data);
    end
    n_checks++;
    if (busy_mask !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask);
    end
    idle();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
    tick();
    n_checks++;
    if (rs1_read_data !== 32'hDEAD_BEEF || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_rs1: got %h valid=%b want deadbeef valid=1", rs1_read_data, rd_valid);
    end
    idle();
    rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd3;
    tick();
    n_checks++;
    if (rs2_read_data !== 32'hDEAD_BEEF || rs1_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL stored_r3: rs1=%h rs2=%h want 0/deadbeef", rs1_read_data, rs2_read_data);
    end
    idle();
  endtask

  task automatic test_x0();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    n_checks++;
    if (issue_err !== 1'b0 || busy_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_issue: err=%b busy=%h want 0/0", issue_err, busy_mask);
    end
    idle();
    rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd3;
    tick();
    n_checks++;
    if (rs1_read_data !== 32'h0 || rs2_read_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL x0_read: rs1=%h rs2=%h want 0/deadbeef", rs1_read_data, rs2_read_data);
    end
    idle();
  endtask

  task automatic test_stall();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 32'h0000_0080) begin
      n_fail++; $display("FAIL busy_r7: got %h want 00000080", busy_mask);
    end
    rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_raise: got %b want 1", stall);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rs2_read_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%b rs2=%h want 0/deadbeef", rd_valid, rs2_read_data);
    end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got %b want 0", stall);
    end
    tick();
    n_checks++;
    if (rs2_read_data !== 32'h0000_1234 || rd_valid !== 1'b1 || busy_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL release_read: rs2=%h valid=%b busy=%h want 00001234/1/0",
               rs2_read_data, rd_valid, busy_mask);
    end
    idle();
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    n_checks++;
    if (issue_err !== 1'b0 || busy_mask !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL waw_first: err=%b busy=%h want 0/00000200", issue_err, busy_mask);
    end
    tick();
    n_checks++;
    if (issue_err !== 1'b1 || busy_mask !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL waw_reject: err=%b busy=%h want 1/00000200", issue_err, busy_mask);
    end
    idle();
    tick();
    n_checks++;
    if (issue_err !== 1'b0) begin
      n_fail++; $display("FAIL waw_pulse: err=%b want 0", issue_err);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    n_checks++;
    if (issue_err !== 1'b0 || busy_mask !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL set_beats_clear: err=%b busy=%h want 0/00000200", issue_err, busy_mask);
    end
    idle();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h66;
    tick();
    n_checks++;
    if (busy_mask !== 32'h0) begin
      n_fail++; $display("FAIL waw_cleanup: busy=%h want 0", busy_mask);
    end
    idle();
  endtask

  task automatic test_compose();
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hCAFE_0004;
    issue_valid = 1'b1; issue_rd = 5'd4;
    rd_en = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd9;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL compose_stall: got %b want 0", stall);
    end
    tick();
    n_checks++;
    if (rs1_read_data !== 32'hCAFE_0004 || rs2_read_data !== 32'h66 ||
        busy_mask !== 32'h0000_0010 || issue_err !== 1'b0) begin
      n_fail++;
      $display("FAIL compose: rs1=%h rs2=%h busy=%h err=%b want cafe0004/66/00000010/0",
               rs1_read_data, rs2_read_data, busy_mask, issue_err);
    end
    idle();
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h4;
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd10;
    rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 32'h0000_0480 || rd_valid !== 1'b1 || rs1_read_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%h valid=%b rs1=%h want 00000480/1/deadbeef",
               busy_mask, rd_valid, rs1_read_data);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy_mask !== 32'h0 || rd_valid !== 1'b0 || rs1_read_data !== 32'h0 ||
        rs2_read_data !== 32'h0 || issue_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%h valid=%b rs1=%h rs2=%h err=%b want all 0",
               busy_mask, rd_valid, rs1_read_data, rs2_read_data, issue_err);
    end
    tick();
    rst = 1'b1;
    rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd9;
    tick();
    n_checks++;
    if (rs1_read_data !== 32'h0 || rs2_read_data !== 32'h0 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_read: rs1=%h rs2=%h valid=%b want 0/0/1",
               rs1_read_data, rs2_read_data, rd_valid);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_stall();
    test_waw();
    test_compose();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
